mem_arbiter: RTL
================

// Module: mem_arbiter
// PURPOSE
//  Shares the single simulation memory port between the I-cache (read-only) and D-cache (read/write) requesters.
//  Latches strobe pulses, grants one request at a time round-robin, sequences downstream strobe/done, returns data.
//  Adds a watchdog so a stuck memory cannot hang the core.
//  Sits between the cache miss logic and the memory model in the Verilator top.
// PARAMETERS
//  ADDR_WIDTH     32   address width, all ports
//  DATA_WIDTH     32   data width, all ports
//  TIMEOUT_CYCLES 255  max WAIT cycles before forced error response; 0 disables watchdog
// PORTS
//  clk              in   1           single clock, all state on posedge
//  rst              in   1           synchronous, active-high reset
//  strobe_icache_i  in   1           1-cycle I-cache read request pulse
//  addr_icache_i    in   ADDR_WIDTH  I-cache address, sampled with strobe
//  rdata_icache_o   out  DATA_WIDTH  I-cache read data, valid while done_icache_o
//  done_icache_o    out  1           1-cycle I-cache completion pulse
//  strobe_dcache_i  in   1           1-cycle D-cache request pulse
//  addr_dcache_i    in   ADDR_WIDTH  D-cache address, sampled with strobe
//  wdata_dcache_i   in   DATA_WIDTH  D-cache write data, sampled with strobe
//  rw_dcache_i      in   1           1=write, 0=read, sampled with strobe
//  rdata_dcache_o   out  DATA_WIDTH  D-cache read data, valid while done_dcache_o (0 on writes)
//  done_dcache_o    out  1           1-cycle D-cache completion pulse
//  mem_strobe_o     out  1           1-cycle request pulse to memory
//  mem_addr_o       out  ADDR_WIDTH  granted address, stable from ISSUE through WAIT
//  mem_wdata_o      out  DATA_WIDTH  granted write data
//  mem_rw_o         out  1           granted direction (I-cache always 0)
//  mem_rdata_i      in   DATA_WIDTH  memory read data, sampled on mem_done_i
//  mem_done_i       in   1           memory completion pulse
//  timeout_o        out  1           sticky: a watchdog expiry occurred; cleared only by rst
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; both pending flags cleared; last_grant=ICACHE (D-cache wins first tie).
//  Capture: strobe_x_i sets pend_x and registers addr/wdata/rw at the same edge.
//   - A strobe while pend_x is already set, or while port x is granted, is ignored; the bench asserts it never happens.
//  FSM states: IDLE, ISSUE, WAIT, RESP (2-bit).
//   - IDLE: if any pend, grant -> ISSUE. Single pend: grant it. Both pend: grant the port != last_grant.
//     On grant, update last_grant and clear the granted pend; the other pend is kept.
//   - ISSUE: mem_strobe_o=1 for exactly this cycle; mem_addr/wdata/rw driven from the granted latch.
//     mem_done_i here is accepted (-> RESP); otherwise -> WAIT.
//   - WAIT: on mem_done_i, capture mem_rdata_i -> RESP. Watchdog counter (8+ bits) counts WAIT cycles;
//     reaching TIMEOUT_CYCLES (nonzero) -> RESP with data 32'hDEADBEEF and timeout_o set.
//   - RESP: done_x_o=1 and rdata_x_o=captured data for the granted port only, one cycle -> IDLE.
//  Latency: strobe at cycle 0 -> pend at 1 -> ISSUE at 2 (mem_strobe_o) -> mem_done_i at k>=2 -> done_x_o at k+1.
//   Minimum 3 cycles; a competing pending request adds its full transaction time.
//  rdata_x_o holds its last value outside done; write completions return 0 on rdata_dcache_o.
//  mem_done_i in IDLE or RESP (stray/late after timeout) is ignored; it does not alter state or outputs.
//  Simultaneous: both strobes in the same cycle both latch; arbitration follows next cycle.
//   A strobe arriving during RESP for the other port is latched normally.
//  Reset mid-transaction: FSM -> IDLE, pends dropped, no done pulse issued; the in-flight memory access is abandoned.
//  Watchdog counter clears on entry to ISSUE; it does not count in other states.
// STRUCTURE
//  Package mem_arb_pkg: arb_state_t {IDLE,ISSUE,WAIT,RESP}, requester_t {ICACHE,DCACHE}, TIMEOUT_DATA=32'hDEADBEEF.
//  Sub-module req_latch (pend flag + addr/wdata/rw capture, clear-on-grant), instantiated twice (I, D).
//  Top holds the FSM, round-robin pointer, watchdog, response data register and output decode.
// TESTING
//  1. I read alone, memory done 4 cycles after strobe: addr 0x100 -> mem_addr_o=0x100, rw=0; done_icache_o 1 cycle, rdata=mem[0x100].
//  2. D write 0xCAFEF00D @0x200, then D read @0x200 -> rdata_dcache_o=0xCAFEF00D; rdata=0 on the write done.
//  3. Both strobes in the same cycle after reset -> D granted first, I second.
//     Repeated ties alternate D,I,D,I; neither port starves over 20 requests.
//  4. TIMEOUT_CYCLES=16, memory never done -> done pulse at WAIT+16 with 0xDEADBEEF; timeout_o=1 until rst.
//     Later stray mem_done_i is ignored.
//  5. rst asserted in WAIT -> next cycle state IDLE, all outputs 0, no done pulse.
//     A new I request afterwards completes normally.
//  6. mem_done_i in the same cycle as mem_strobe_o (zero-latency memory) -> done_x_o exactly one cycle later; no extra mem_strobe_o.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory-port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

  typedef enum logic {
    ICACHE = 1'b0,
    DCACHE = 1'b1
  } requester_t;

  // Data returned to the requester when the watchdog gives up on memory.
  localparam logic [31:0] TIMEOUT_DATA = 32'hDEADBEEF;

  // Round-robin choice: a lone requester wins outright, a tie goes to the
  // port that was not served last.
  function automatic requester_t rr_pick(logic pend_i, logic pend_d, requester_t last);
    if (pend_i && pend_d) begin
      return (last == ICACHE) ? DCACHE : ICACHE;
    end
    return pend_d ? DCACHE : ICACHE;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the I-cache, D-cache and memory-side signals of the arbiter.
// slave is the arbiter's view; master is the view of the surrounding system.
interface mem_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  strobe_icache_i;
  logic [ADDR_WIDTH-1:0] addr_icache_i;
  logic [DATA_WIDTH-1:0] rdata_icache_o;
  logic                  done_icache_o;
  logic                  strobe_dcache_i;
  logic [ADDR_WIDTH-1:0] addr_dcache_i;
  logic [DATA_WIDTH-1:0] wdata_dcache_i;
  logic                  rw_dcache_i;
  logic [DATA_WIDTH-1:0] rdata_dcache_o;
  logic                  done_dcache_o;
  logic                  mem_strobe_o;
  logic [ADDR_WIDTH-1:0] mem_addr_o;
  logic [DATA_WIDTH-1:0] mem_wdata_o;
  logic                  mem_rw_o;
  logic [DATA_WIDTH-1:0] mem_rdata_i;
  logic                  mem_done_i;
  logic                  timeout_o;

  modport slave (
    input  strobe_icache_i, addr_icache_i,
    input  strobe_dcache_i, addr_dcache_i, wdata_dcache_i, rw_dcache_i,
    input  mem_rdata_i, mem_done_i,
    output rdata_icache_o, done_icache_o,
    output rdata_dcache_o, done_dcache_o,
    output mem_strobe_o, mem_addr_o, mem_wdata_o, mem_rw_o,
    output timeout_o
  );

  modport master (
    output strobe_icache_i, addr_icache_i,
    output strobe_dcache_i, addr_dcache_i, wdata_dcache_i, rw_dcache_i,
    output mem_rdata_i, mem_done_i,
    input  rdata_icache_o, done_icache_o,
    input  rdata_dcache_o, done_dcache_o,
    input  mem_strobe_o, mem_addr_o, mem_wdata_o, mem_rw_o,
    input  timeout_o
  );
endinterface

// File: rtl/req_latch.sv
// One requester's pending flag plus its captured address/data/direction.
// A strobe is taken only when nothing is pending and the port is not being
// served; the latched fields stay put until the next accepted strobe.
module req_latch #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  strobe,
  input  logic                  hold,
  input  logic                  clear,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic                  req_rw,
  output logic                  pend,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [DATA_WIDTH-1:0] wdata,
  output logic                  rw
);

  logic                  pend_reg;
  logic [ADDR_WIDTH-1:0] addr_reg;
  logic [DATA_WIDTH-1:0] wdata_reg;
  logic                  rw_reg;

  // Capture on an accepted strobe; grant clears only the pending flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_reg  <= 1'b0;
      addr_reg  <= '0;
      wdata_reg <= '0;
      rw_reg    <= 1'b0;
    end else if (clear) begin
      pend_reg <= 1'b0;
    end else if (strobe && !pend_reg && !hold) begin
      pend_reg  <= 1'b1;
      addr_reg  <= req_addr;
      wdata_reg <= req_wdata;
      rw_reg    <= req_rw;
    end
  end

  assign pend  = pend_reg;
  assign addr  = addr_reg;
  assign wdata = wdata_reg;
  assign rw    = rw_reg;

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester arbiter for the single memory port: latches I/D requests,
// grants round-robin, sequences the memory strobe/done handshake, returns
// data, and forces an error response if memory never answers.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus
);

  localparam bit WD_ON = (TIMEOUT_CYCLES != 0);
  localparam int WD_W  = (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(WD_ON ? TIMEOUT_CYCLES - 1 : 0);

  arb_state_t state_reg, state_next;
  requester_t last_grant_reg, grant_pick;
  logic       grant_en, take_done, take_timeout;

  logic [WD_W-1:0]       wd_cnt_reg;
  logic [DATA_WIDTH-1:0] rdata_icache_reg, rdata_dcache_reg, resp_data;
  logic                  timeout_reg;

  // Per-port request plumbing, index 0 = I-cache, 1 = D-cache.
  logic [1:0]            req_strobe, req_hold, req_clear, req_pend, req_rw, lat_rw;
  logic [ADDR_WIDTH-1:0] req_addr  [2];
  logic [ADDR_WIDTH-1:0] lat_addr  [2];
  logic [DATA_WIDTH-1:0] req_wdata [2];
  logic [DATA_WIDTH-1:0] lat_wdata [2];

  assign req_strobe   = {bus.strobe_dcache_i, bus.strobe_icache_i};
  assign req_addr[0]  = bus.addr_icache_i;
  assign req_addr[1]  = bus.addr_dcache_i;
  assign req_wdata[0] = '0;                // I-cache never writes
  assign req_wdata[1] = bus.wdata_dcache_i;
  assign req_rw       = {bus.rw_dcache_i, 1'b0};

  for (genvar gi = 0; gi < 2; gi++) begin : g_port
    // The port being served ignores strobes until it is back in IDLE.
    assign req_hold[gi]  = (state_reg != IDLE) && (last_grant_reg == requester_t'(1'(gi)));
    assign req_clear[gi] = grant_en && (grant_pick == requester_t'(1'(gi)));

    req_latch #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DATA_WIDTH (DATA_WIDTH)
    ) u_latch (
      .clk       (clk),
      .rst       (rst),
      .strobe    (req_strobe[gi]),
      .hold      (req_hold[gi]),
      .clear     (req_clear[gi]),
      .req_addr  (req_addr[gi]),
      .req_wdata (req_wdata[gi]),
      .req_rw    (req_rw[gi]),
      .pend      (req_pend[gi]),
      .addr      (lat_addr[gi]),
      .wdata     (lat_wdata[gi]),
      .rw        (lat_rw[gi])
    );
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Next state, grant decision and completion causes.
  always_comb begin
    state_next   = state_reg;
    grant_en     = 1'b0;
    grant_pick   = last_grant_reg;
    take_done    = 1'b0;
    take_timeout = 1'b0;
    case (state_reg)
      IDLE: begin
        if (|req_pend) begin
          grant_en   = 1'b1;
          grant_pick = rr_pick(req_pend[0], req_pend[1], last_grant_reg);
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        if (bus.mem_done_i) begin
          take_done  = 1'b1;
          state_next = RESP;
        end else begin
          state_next = WAIT;
        end
      end
      WAIT: begin
        // A real completion on the expiry cycle wins over the watchdog.
        if (bus.mem_done_i) begin
          take_done  = 1'b1;
          state_next = RESP;
        end else if (WD_ON && (wd_cnt_reg == WD_LAST)) begin
          take_timeout = 1'b1;
          state_next   = RESP;
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Round-robin pointer; also identifies the port in service.
  always_ff @(posedge clk) begin
    if (rst)           last_grant_reg <= ICACHE;
    else if (grant_en) last_grant_reg <= grant_pick;
  end

  // Watchdog: zeroed while issuing, counts WAIT cycles only.
  always_ff @(posedge clk) begin
    if (rst)                   wd_cnt_reg <= '0;
    else if (state_reg == ISSUE) wd_cnt_reg <= '0;
    else if (state_reg == WAIT)  wd_cnt_reg <= wd_cnt_reg + WD_W'(1);
  end

  // Response payload: error pattern on expiry, zero for writes, else memory data.
  always_comb begin
    resp_data = bus.mem_rdata_i;
    if (take_timeout)                  resp_data = DATA_WIDTH'(TIMEOUT_DATA);
    else if (lat_rw[last_grant_reg])   resp_data = '0;
  end

  // Per-port read-data holding registers and the sticky timeout flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_icache_reg <= '0;
      rdata_dcache_reg <= '0;
      timeout_reg      <= 1'b0;
    end else begin
      if (take_done || take_timeout) begin
        if (last_grant_reg == ICACHE) rdata_icache_reg <= resp_data;
        else                          rdata_dcache_reg <= resp_data;
      end
      if (take_timeout) timeout_reg <= 1'b1;
    end
  end

  assign bus.done_icache_o  = (state_reg == RESP) && (last_grant_reg == ICACHE);
  assign bus.done_dcache_o  = (state_reg == RESP) && (last_grant_reg == DCACHE);
  assign bus.rdata_icache_o = rdata_icache_reg;
  assign bus.rdata_dcache_o = rdata_dcache_reg;
  assign bus.mem_strobe_o   = (state_reg == ISSUE);
  assign bus.mem_addr_o     = lat_addr[last_grant_reg];
  assign bus.mem_wdata_o    = lat_wdata[last_grant_reg];
  assign bus.mem_rw_o       = lat_rw[last_grant_reg];
  assign bus.timeout_o      = timeout_reg;

endmodule
